// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pkg                                                          |
// | Shared datapath width and FSM state encoding for serial_addsub.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package alu_pkg;

  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/addsub_chunk.sv
`default_nettype none
// +------------------------------------------------------------------+
// | addsub_chunk                                                     |
// | One CHUNK_W-bit add/subtract slice with carry and MSB carry-in.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module addsub_chunk #(
  parameter int CHUNK_W = 32
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               mode,
  input  logic               cin,
  output logic [CHUNK_W-1:0] sum,
  output logic               cout,
  output logic               msb_cin
);

  logic [CHUNK_W-1:0] w_b_eff;
  logic [CHUNK_W:0]   w_full;

  assign w_b_eff = mode ? ~b : b;
  assign w_full  = {1'b0, a} + {1'b0, w_b_eff} + {{CHUNK_W{1'b0}}, cin};
  assign sum     = w_full[CHUNK_W-1:0];
  assign cout    = w_full[CHUNK_W];
  // Carry into the top bit recovered from its sum bit and operand bits.
  assign msb_cin = w_full[CHUNK_W-1] ^ a[CHUNK_W-1] ^ w_b_eff[CHUNK_W-1];

endmodule : addsub_chunk
`default_nettype wire

// File: rtl/serial_addsub_128.sv
`default_nettype none
// +------------------------------------------------------------------+
// | serial_addsub_128                                                |
// | 128-bit add/subtract computed one CHUNK_W slice per clock.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module serial_addsub_128
  import alu_pkg::*;
#(
  parameter int CHUNK_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              cout,
  output logic              ovf
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  state_t             r_state;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic               r_mode;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic [CHUNK_W-1:0] w_sum;
  logic               w_cout;
  logic               w_msb_cin;

  // Operands shift right each slice so the adder always sees the low chunk.
  addsub_chunk #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk (
    .a       (r_a[CHUNK_W-1:0]),
    .b       (r_b[CHUNK_W-1:0]),
    .mode    (r_mode),
    .cin     (r_carry),
    .sum     (w_sum),
    .cout    (w_cout),
    .msb_cin (w_msb_cin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_mode  <= mode;
            r_carry <= mode;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Result fills from the top; after NCHUNK shifts slice 0 sits at the LSB.
          result  <= {w_sum, result[DATA_W-1:CHUNK_W]};
          r_a     <= r_a >> CHUNK_W;
          r_b     <= r_b >> CHUNK_W;
          r_carry <= w_cout;
          if (r_cnt == LAST_CNT) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            cout    <= w_cout;
            ovf     <= w_cout ^ w_msb_cin;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : serial_addsub_128
`default_nettype wire

// File: doc/serial_addsub_128.md
SERIAL_ADDSUB_128 -- requirements
Module: serial_addsub_128

Interface
REQ-001 SHALL have parameter CHUNK_W, default 32, meaning adder slice width in bits; legal values are 16, 32 and 64.
REQ-002 SHALL have local constant NCHUNK = 128/CHUNK_W, which sets the number of slice cycles per operation.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request; operands are sampled when start=1 in IDLE.
REQ-007 mode  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-008 a  input  128  operand A, two's complement.
REQ-009 b  input  128  operand B, two's complement.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse when result, cout and ovf are valid.
REQ-012 result  output  128  sum or difference, modulo 2^128.
REQ-013 cout  output  1  carry out of bit 127; feeds flag-generator cin.
REQ-014 ovf  output  1  signed overflow.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 IDLE with start=1 at an edge SHALL:
- capture a, b and mode;
- preload the carry register with mode;
- clear the chunk counter;
- go to RUN.
REQ-017 Start SHALL be ignored in RUN and DONE, with no queuing.
REQ-018 Each RUN edge SHALL compute one slice, LSB slice first:
- slice = a_slice + (mode ? ~b_slice : b_slice) + carry;
- write the slice into result;
- update carry;
- increment the counter.
REQ-019 After the edge that computes slice NCHUNK-1, the FSM SHALL:
- go to DONE;
- set done=1;
- set cout = final carry;
- set ovf = carry-in of bit 127 XOR carry-out of bit 127.
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-021 Latency: for start sampled at edge N, done SHALL be high from edge N+NCHUNK to edge N+NCHUNK+1 (4 cycles at default).
REQ-022 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-023 result, cout and ovf SHALL hold their values after DONE until the next accepted start.
REQ-024 The result register MAY show partial slices during RUN, and consumers SHALL sample result only on done.
REQ-025 Operand changes after the capture edge SHALL NOT affect the result.
REQ-026 In subtract mode, cout=1 SHALL mean no borrow (a >= b unsigned).
REQ-027 The chunk counter SHALL be $clog2(NCHUNK) bits wide and SHALL stop at NCHUNK-1 without wrapping into a further slice.

Reset
REQ-028 rst_n=0 SHALL immediately force, regardless of clk:
- state to IDLE;
- busy, done, cout and ovf to 0;
- result to 0;
- counter and carry to 0.
REQ-029 Reset during RUN SHALL abort the operation, with no done pulse.
REQ-030 After rst_n deasserts, the first start SHALL be accepted normally.

Structure
REQ-031 Shared package alu_pkg SHALL hold:
- the FSM state enum;
- the constant DATA_W = 128.
REQ-032 A single sub-module addsub_chunk SHALL exist:
- parameter CHUNK_W;
- inputs: a, b, mode, cin;
- outputs: sum, cout, and msb carry-in (for ovf).
REQ-033 The carry chain SHALL be confined to one CHUNK_W slice per cycle, with no full 128-bit combinational adder.

Verification
REQ-034 Add 5+3, mode=0 -> result=8, cout=0, ovf=0; done exactly 4 cycles after start; busy high 4 cycles.
REQ-035 Add a=2^128-1, b=1 -> result=0, cout=1, ovf=0 (carry ripples across all slices).
REQ-036 Add a=0x7FFF...F, b=1 -> result=0x8000...0, ovf=1, cout=0.
REQ-037 Subtract both orders:
- 3-5 -> result=0xFFFF...FE, cout=0, ovf=0;
- 5-3 -> result=2, cout=1.
REQ-038 Start pulsed in cycle 2 of RUN with new operands -> ignored; the first result completes unchanged.
REQ-039 rst_n low in RUN -> all outputs 0, no done pulse; after release, 1+1 -> result=2.
